multicycle_control_fsm: RTL and testbench

//  Main control FSM of the multicycle RV32I core; sits directly upstream of the ALU decoder.

---
 rtl/ctrl_pkg.sv | 66 ++++++
 rtl/ctrl_imm_sel.sv | 21 ++
 rtl/multicycle_control_fsm.sv | 143 ++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I main control FSM.
package ctrl_pkg;

    localparam int unsigned STATE_BITS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADR   = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        EXEC_LUI  = 4'd8,
        ALU_WB    = 4'd9,
        BEQ       = 4'd10,
        JAL       = 4'd11,
        TRAP      = 4'd12
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASS  = 2'b11;

    // Opcode dispatch out of DECODE; anything unsupported traps.
    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW: return MEM_ADR;
            OP_R:         return EXEC_R;
            OP_I:         return EXEC_I;
            OP_LUI:       return EXEC_LUI;
            OP_BEQ:       return BEQ;
            OP_JAL:       return JAL;
            default:      return TRAP;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_imm_sel.sv
// Immediate-format select for the control FSM, from current state and opcode.
module ctrl_imm_sel
    import ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [6:0]  op,
    output logic [2:0]  imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (state)
            DECODE:   imm_src = (op == OP_JAL) ? IMM_J : IMM_B;
            MEM_ADR:  imm_src = (op == OP_SW) ? IMM_S : IMM_I;
            EXEC_I:   imm_src = IMM_I;
            EXEC_LUI: imm_src = IMM_U;
            default:  imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences each instruction
// and drives datapath selects and write strobes.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_EN = 1,
    parameter int unsigned STATE_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         imm_src,
    output logic [1:0]         alu_op,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    state_t state, state_next;
    logic   ready;
    logic   pc_update, branch;
    logic   mem_write_s, ir_write_s, reg_write_s, illegal_s;

    assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = FETCH;
        adr_src     = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RD2;
        alu_op      = ALU_ADD;
        pc_update   = 1'b0;
        branch      = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        illegal_s   = 1'b0;
        case (state)
            FETCH: begin
                result_src = RES_ALURESULT;
                alu_src_b  = SRCB_FOUR;
                if (ready) begin
                    ir_write_s = 1'b1;
                    pc_update  = 1'b1;
                    state_next = DECODE;
                end else begin
                    state_next = FETCH;
                end
            end
            DECODE: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_IMM;
                state_next = decode_next(op);
            end
            MEM_ADR: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_IMM;
                state_next = (op == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                adr_src    = 1'b1;
                state_next = ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                result_src  = RES_DATA;
                reg_write_s = 1'b1;
                state_next  = FETCH;
            end
            MEM_WRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
                state_next  = ready ? FETCH : MEM_WRITE;
            end
            EXEC_R: begin
                alu_src_a  = SRCA_RD1;
                alu_op     = ALU_FUNCT;
                state_next = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_FUNCT;
                state_next = ALU_WB;
            end
            EXEC_LUI: begin
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_PASS;
                state_next = ALU_WB;
            end
            ALU_WB: begin
                reg_write_s = 1'b1;
                state_next  = FETCH;
            end
            BEQ: begin
                alu_src_a  = SRCA_RD1;
                alu_op     = ALU_SUB;
                branch     = 1'b1;
                state_next = FETCH;
            end
            JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_update  = 1'b1;
                state_next = ALU_WB;
            end
            TRAP: begin
                illegal_s  = 1'b1;
                state_next = TRAP;
            end
            default: state_next = FETCH;
        endcase
    end

    ctrl_imm_sel u_imm_sel (
        .state   (state),
        .op      (op),
        .imm_src (imm_src)
    );

    // Strobes are masked by rst_n so nothing leaks out in the reset cycle itself.
    assign pc_write   = rst_n & (pc_update | (branch & zero));
    assign mem_write  = rst_n & mem_write_s;
    assign ir_write   = rst_n & ir_write_s;
    assign reg_write  = rst_n & reg_write_s;
    assign illegal_op = rst_n & illegal_s;
    assign state_dbg  = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-instruction timelines feed
// an expectation queue that a negedge monitor drains.
module tb_multicycle_control_fsm;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       zero, mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic [3:0] state_dbg;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_WAIT_EN(1), .STATE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .alu_op     (alu_op),
        .illegal_op (illegal_op),
        .state_dbg  (state_dbg)
    );

    typedef struct packed {
        state_t     st;
        logic       pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, a, b, aop;
        logic [2:0] imm;
    } exp_t;

    exp_t        sb[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    function automatic exp_t mk(input state_t s);
        exp_t e;
        e    = '0;
        e.st = s;
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock of stimulus with the outputs expected during that clock.
    task automatic cyc(input exp_t e, input logic rdy, input logic z, input logic [6:0] opv);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = rdy;
        zero      = z;
        op        = opv;
        sb.push_back(e);
    endtask

    // Reset asserted for one clock; selects sit at FETCH values, strobes all low.
    task automatic reset_cycle();
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        mem_ready = rbit();
        zero      = rbit();
        e         = mk(FETCH);
        e.b       = 2'b10;
        e.rs      = 2'b10;
        sb.push_back(e);
    endtask

    task automatic alu_wb(input logic [6:0] opv);
        exp_t e;
        e    = mk(ALU_WB);
        e.rw = 1'b1;
        cyc(e, rbit(), rbit(), opv);
    endtask

    task automatic run_instr(input logic [6:0] opv, input int unsigned fw,
                             input int unsigned mwait, input logic bz, input logic abort);
        exp_t        e;
        int unsigned w;
        e      = mk(FETCH);
        e.b    = 2'b10;
        e.rs   = 2'b10;
        for (int unsigned i = 0; i < fw; i++) cyc(e, 1'b0, rbit(), opv);
        e.irw  = 1'b1;
        e.pcw  = 1'b1;
        cyc(e, 1'b1, rbit(), opv);

        e      = mk(DECODE);
        e.a    = 2'b01;
        e.b    = 2'b01;
        e.imm  = (opv == OP_JAL) ? 3'b011 : 3'b010;
        cyc(e, rbit(), rbit(), opv);

        case (opv)
            OP_LW, OP_SW: begin
                e     = mk(MEM_ADR);
                e.a   = 2'b10;
                e.b   = 2'b01;
                e.imm = (opv == OP_SW) ? 3'b001 : 3'b000;
                cyc(e, rbit(), rbit(), opv);
                if (opv == OP_LW) begin
                    e     = mk(MEM_READ);
                    e.adr = 1'b1;
                    for (int unsigned i = 0; i < mwait; i++) cyc(e, 1'b0, rbit(), opv);
                    cyc(e, 1'b1, rbit(), opv);
                    e     = mk(MEM_WB);
                    e.rs  = 2'b01;
                    e.rw  = 1'b1;
                    cyc(e, rbit(), rbit(), opv);
                end else begin
                    e     = mk(MEM_WRITE);
                    e.adr = 1'b1;
                    e.mw  = 1'b1;
                    w     = (abort && mwait == 0) ? 1 : mwait;
                    for (int unsigned i = 0; i < w; i++) cyc(e, 1'b0, rbit(), opv);
                    if (abort) reset_cycle();
                    else       cyc(e, 1'b1, rbit(), opv);
                end
            end
            OP_R: begin
                e     = mk(EXEC_R);
                e.a   = 2'b10;
                e.aop = 2'b10;
                cyc(e, rbit(), rbit(), opv);
                alu_wb(opv);
            end
            OP_I: begin
                e     = mk(EXEC_I);
                e.a   = 2'b10;
                e.b   = 2'b01;
                e.aop = 2'b10;
                cyc(e, rbit(), rbit(), opv);
                alu_wb(opv);
            end
            OP_LUI: begin
                e     = mk(EXEC_LUI);
                e.b   = 2'b01;
                e.imm = 3'b100;
                e.aop = 2'b11;
                cyc(e, rbit(), rbit(), opv);
                alu_wb(opv);
            end
            OP_BEQ: begin
                e     = mk(BEQ);
                e.a   = 2'b10;
                e.aop = 2'b01;
                e.pcw = bz;
                cyc(e, rbit(), bz, opv);
            end
            OP_JAL: begin
                e     = mk(JAL);
                e.a   = 2'b01;
                e.b   = 2'b10;
                e.pcw = 1'b1;
                cyc(e, rbit(), rbit(), opv);
                alu_wb(opv);
            end
            default: begin
                e     = mk(TRAP);
                e.ill = 1'b1;
                for (int unsigned i = 0; i < 10; i++) cyc(e, rbit(), rbit(), 7'($urandom));
                reset_cycle();
            end
        endcase
    endtask

    task automatic chk(input string nm, input int unsigned act, input int unsigned exv,
                       inout int unsigned bad);
        if (act != exv) begin
            $display("FAIL %s: got %0h want %0h (vector %0d, t=%0t)", nm, act, exv, vectors, $time);
            bad++;
        end
    endtask

    initial begin
        exp_t        e;
        int unsigned bad;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                bad = 0;
                chk("state_dbg",  state_dbg,  e.st,  bad);
                chk("pc_write",   pc_write,   e.pcw, bad);
                chk("adr_src",    adr_src,    e.adr, bad);
                chk("mem_write",  mem_write,  e.mw,  bad);
                chk("ir_write",   ir_write,   e.irw, bad);
                chk("reg_write",  reg_write,  e.rw,  bad);
                chk("illegal_op", illegal_op, e.ill, bad);
                chk("result_src", result_src, e.rs,  bad);
                chk("alu_src_a",  alu_src_a,  e.a,   bad);
                chk("alu_src_b",  alu_src_b,  e.b,   bad);
                chk("alu_op",     alu_op,     e.aop, bad);
                chk("imm_src",    imm_src,    e.imm, bad);
                vectors++;
                if (bad != 0) miscompares++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timed out");
    end

    localparam logic [6:0] LEGAL [7] = '{OP_LW, OP_SW, OP_R, OP_I, OP_LUI, OP_BEQ, OP_JAL};

    initial begin
        logic [6:0] opv;
        logic       legal;
        rst_n     = 1'b0;
        op        = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        reset_cycle();

        run_instr(OP_LW,  0, 0, 1'b0, 1'b0);
        run_instr(OP_SW,  0, 2, 1'b0, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b1, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b0, 1'b0);
        run_instr(OP_LUI, 0, 0, 1'b0, 1'b0);
        run_instr(7'b1111111, 0, 0, 1'b0, 1'b0);
        run_instr(OP_SW,  1, 1, 1'b0, 1'b1);
        run_instr(OP_JAL, 2, 0, 1'b0, 1'b0);
        run_instr(OP_R,   0, 0, 1'b0, 1'b0);
        run_instr(OP_I,   0, 0, 1'b0, 1'b0);

        for (int unsigned n = 0; n < 200; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                do begin
                    opv   = 7'($urandom);
                    legal = 1'b0;
                    for (int k = 0; k < 7; k++) if (opv == LEGAL[k]) legal = 1'b1;
                end while (legal);
            end else begin
                opv = LEGAL[$urandom_range(0, 6)];
            end
            run_instr(opv, $urandom_range(0, 2), $urandom_range(0, 3), rbit(),
                       ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            $display("FAIL drain: got %0d pending want 0", sb.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
